// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : servo_pkg
// Brief    : Shared types, state encodings and helpers for the multi-channel
//            servo controller.
// Revision : 1.0 - initial release
// ============================================================================
package servo_pkg;

  localparam int POS_W_DEF  = 12;
  localparam int DUTY_W_DEF = 18;
  localparam int ACC_W      = 32;

  typedef logic [POS_W_DEF-1:0]     pos_t;
  typedef logic [DUTY_W_DEF-1:0]    duty_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Sequencer states: one LOAD/CALC/WRITE triple per channel.
  typedef logic [2:0] seq_state_e;
  localparam seq_state_e c_seq_idle  = 3'd0;
  localparam seq_state_e c_seq_load  = 3'd1;
  localparam seq_state_e c_seq_calc  = 3'd2;
  localparam seq_state_e c_seq_write = 3'd3;
  localparam seq_state_e c_seq_done  = 3'd4;

  // Per-channel overcurrent supervisor states.
  typedef logic [1:0] flt_state_e;
  localparam flt_state_e c_flt_run      = 2'd0;
  localparam flt_state_e c_flt_fault    = 2'd1;
  localparam flt_state_e c_flt_cooldown = 2'd2;

  // Clamp v into [lo, hi].
  function automatic acc_t sat_clamp(input acc_t v, input acc_t lo, input acc_t hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pid_core.sv
`default_nettype none
// ============================================================================
// Module   : servo_pid_core
// Brief    : Combinational PID step for one channel: error, saturating
//            integrator, derivative, scaled sum and duty clamp.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pid_core
  import servo_pkg::*;
#(
  parameter int               POS_W      = 12,
  parameter int               DUTY_W     = 18,
  parameter int               PWM_PERIOD = 200000,
  parameter logic signed [7:0] KP        = 8'sd8,
  parameter logic signed [7:0] KI        = 8'sd1,
  parameter logic signed [7:0] KD        = 8'sd2,
  parameter int               GAIN_SHIFT = 4,
  parameter int               INT_MAX    = 32767,
  parameter int               DUTY_MID   = 15000
) (
  input  logic [POS_W-1:0]        i_sp,
  input  logic [POS_W-1:0]        i_pos,
  input  acc_t                    i_integ,
  input  logic signed [POS_W:0]   i_prev_err,
  output logic signed [POS_W:0]   o_err,
  output acc_t                    o_integ,
  output logic [DUTY_W-1:0]       o_duty
);

  localparam acc_t c_kp       = acc_t'(KP);
  localparam acc_t c_ki       = acc_t'(KI);
  localparam acc_t c_kd       = acc_t'(KD);
  localparam acc_t c_int_max  = acc_t'(INT_MAX);
  localparam acc_t c_int_min  = -acc_t'(INT_MAX);
  localparam acc_t c_duty_mid = acc_t'(DUTY_MID);
  localparam acc_t c_duty_max = acc_t'(PWM_PERIOD);

  logic signed [POS_W:0] w_err;
  acc_t w_err_x, w_prev_x, w_integ, w_d, w_sum, w_u;

  // Error is formed one bit wider than the operands so it never wraps.
  assign w_err    = $signed({1'b0, i_sp}) - $signed({1'b0, i_pos});
  assign w_err_x  = acc_t'(w_err);
  assign w_prev_x = acc_t'(i_prev_err);
  assign w_integ  = sat_clamp(i_integ + w_err_x, c_int_min, c_int_max);
  assign w_d      = w_err_x - w_prev_x;
  assign w_sum    = c_kp * w_err_x + c_ki * w_integ + c_kd * w_d;
  assign w_u      = w_sum >>> GAIN_SHIFT;

  assign o_err   = w_err;
  assign o_integ = w_integ;
  assign o_duty  = DUTY_W'(sat_clamp(c_duty_mid + w_u, acc_t'(0), c_duty_max));

endmodule
`default_nettype wire

// File: rtl/servo_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : servo_ctrl_multi
// Brief    : N-channel servo controller. A single time-shared PID datapath
//            updates every channel once per PWM period; per-channel
//            overcurrent supervisors force the drive off, cool down and retry.
// Config   : SERVO_SOFT_START_EN - slew-limit each setpoint by SLEW_STEP
//            counts per period before it reaches the PID.
// Revision : 1.0 - initial release
// ============================================================================
module servo_ctrl_multi
  import servo_pkg::*;
#(
  parameter int                N_CH       = 4,
  parameter int                POS_W      = 12,
  parameter int                DUTY_W     = 18,
  parameter int                PWM_PERIOD = 200000,
  parameter logic signed [7:0] KP         = 8'sd8,
  parameter logic signed [7:0] KI         = 8'sd1,
  parameter logic signed [7:0] KD         = 8'sd2,
  parameter int                GAIN_SHIFT = 4,
  parameter int                INT_MAX    = 32767,
  parameter int                DUTY_MID   = 15000,
  parameter int                OC_FILT    = 8,
  parameter int                COOLDOWN   = 4,
  parameter int                SLEW_STEP  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*POS_W-1:0]   setpoint,
  input  logic [N_CH*POS_W-1:0]   position,
  input  logic [N_CH*POS_W-1:0]   current,
  input  logic [POS_W-1:0]        i_limit,
  input  logic                    fault_clr,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH-1:0]         fault,
  output logic                    upd_done
);

  localparam int                  c_ch_w     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int                  c_oc_w     = $clog2(OC_FILT + 1);
  localparam int                  c_cd_w     = $clog2(COOLDOWN + 1);
  localparam logic [DUTY_W-1:0]   c_cnt_last = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [c_ch_w-1:0]   c_ch_last  = c_ch_w'(N_CH - 1);

  if (PWM_PERIOD >= 2**DUTY_W || PWM_PERIOD <= 3*N_CH+2 || SLEW_STEP < 1) begin : g_bad_cfg
    $error("servo_ctrl_multi: unsupported parameter combination");
  end

  logic [POS_W-1:0]      w_sp_ch  [N_CH];
  logic [POS_W-1:0]      w_pos_ch [N_CH];
  logic [POS_W-1:0]      w_cur_ch [N_CH];
  logic [DUTY_W-1:0]     r_duty_act [N_CH];
  logic [DUTY_W-1:0]     r_duty_nxt [N_CH];
  acc_t                  r_integ    [N_CH];
  logic signed [POS_W:0] r_prev     [N_CH];
  logic [N_CH-1:0]       w_run, w_fault_st, w_trip;

  logic [DUTY_W-1:0]     r_cnt;
  logic                  w_wrap;
  seq_state_e            r_seq_state;
  logic [c_ch_w-1:0]     r_ch;
  logic [POS_W-1:0]      w_sp_use;

  logic [POS_W-1:0]      r_op_sp, r_op_pos;
  acc_t                  r_op_integ;
  logic signed [POS_W:0] r_op_prev;
  logic signed [POS_W:0] w_res_err, r_res_err;
  acc_t                  w_res_integ, r_res_integ;
  logic [DUTY_W-1:0]     w_res_duty, r_res_duty;

  assign w_wrap   = (r_cnt == c_cnt_last);
  assign upd_done = (r_seq_state == c_seq_done);

  // Free-running PWM period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    flt_state_e        r_state;
    logic [c_oc_w-1:0] r_oc_cnt;
    logic [c_cd_w-1:0] r_cd_cnt;
    logic              r_clr_pend;
    logic              w_over;

    assign w_sp_ch[c]    = setpoint[c*POS_W +: POS_W];
    assign w_pos_ch[c]   = position[c*POS_W +: POS_W];
    assign w_cur_ch[c]   = current[c*POS_W +: POS_W];
    assign w_over        = (w_cur_ch[c] > i_limit);
    assign w_run[c]      = (r_state == c_flt_run);
    assign w_fault_st[c] = (r_state == c_flt_fault);
    assign w_trip[c]     = w_run[c] && w_over && (r_oc_cnt == c_oc_w'(OC_FILT - 1));
    assign fault[c]      = !w_run[c];
    assign pwm_out[c]    = (r_cnt < r_duty_act[c]);

    // Overcurrent filter and RUN -> FAULT -> COOLDOWN -> RUN supervisor.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= c_flt_run;
        r_oc_cnt   <= '0;
        r_cd_cnt   <= '0;
        r_clr_pend <= 1'b0;
      end else begin
        case (r_state)
          c_flt_run: begin
            r_clr_pend <= 1'b0;
            r_cd_cnt   <= '0;
            if (w_trip[c]) begin
              r_state  <= c_flt_fault;
              r_oc_cnt <= '0;
            end else if (w_over) begin
              r_oc_cnt <= r_oc_cnt + 1'b1;
            end else begin
              r_oc_cnt <= '0;
            end
          end
          c_flt_fault: begin
            if (w_wrap) begin
              r_state  <= c_flt_cooldown;
              r_cd_cnt <= '0;
            end
          end
          c_flt_cooldown: begin
            if (fault_clr) r_clr_pend <= 1'b1;
            if (w_wrap) begin
              if (r_clr_pend || fault_clr || r_cd_cnt == c_cd_w'(COOLDOWN - 1)) begin
                r_state    <= c_flt_run;
                r_clr_pend <= 1'b0;
                r_cd_cnt   <= '0;
              end else begin
                r_cd_cnt <= r_cd_cnt + 1'b1;
              end
            end
          end
          default: r_state <= c_flt_run;
        endcase
      end
    end
  end

`ifdef SERVO_SOFT_START_EN
  logic [POS_W-1:0]   r_sp_eff [N_CH];
  logic [N_CH-1:0]    r_sp_vld;
  logic [POS_W:0]     w_eff_x, w_tgt_x;
  localparam logic [POS_W:0] c_slew = (POS_W+1)'(SLEW_STEP);

  // Slewed setpoint for the channel currently being loaded.
  always_comb begin
    w_eff_x  = {1'b0, r_sp_eff[r_ch]};
    w_tgt_x  = {1'b0, w_sp_ch[r_ch]};
    w_sp_use = w_sp_ch[r_ch];
    if (w_tgt_x > w_eff_x + c_slew)      w_sp_use = POS_W'(w_eff_x + c_slew);
    else if (w_tgt_x + c_slew < w_eff_x) w_sp_use = POS_W'(w_eff_x - c_slew);
  end

  // Effective setpoints: seeded from position after reset or while faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) r_sp_eff[c] <= '0;
      r_sp_vld <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!r_sp_vld[c] || !w_run[c] || w_trip[c]) begin
          r_sp_eff[c] <= w_pos_ch[c];
          r_sp_vld[c] <= 1'b1;
        end else if (r_seq_state == c_seq_load && r_ch == c_ch_w'(c)) begin
          r_sp_eff[c] <= w_sp_use;
        end
      end
    end
  end
`else
  assign w_sp_use = w_sp_ch[r_ch];
`endif

  // Sequencer plus operand/result pipeline around the shared PID core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_state <= c_seq_idle;
      r_ch        <= '0;
      r_op_sp     <= '0;
      r_op_pos    <= '0;
      r_op_integ  <= '0;
      r_op_prev   <= '0;
      r_res_err   <= '0;
      r_res_integ <= '0;
      r_res_duty  <= '0;
    end else begin
      case (r_seq_state)
        c_seq_idle: begin
          if (r_cnt == '0) begin
            r_seq_state <= c_seq_load;
            r_ch        <= '0;
          end
        end
        c_seq_load: begin
          r_op_sp     <= w_sp_use;
          r_op_pos    <= w_pos_ch[r_ch];
          r_op_integ  <= r_integ[r_ch];
          r_op_prev   <= r_prev[r_ch];
          r_seq_state <= c_seq_calc;
        end
        c_seq_calc: begin
          r_res_err   <= w_res_err;
          r_res_integ <= w_res_integ;
          r_res_duty  <= w_res_duty;
          r_seq_state <= c_seq_write;
        end
        c_seq_write: begin
          if (r_ch == c_ch_last) begin
            r_seq_state <= c_seq_done;
          end else begin
            r_ch        <= r_ch + 1'b1;
            r_seq_state <= c_seq_load;
          end
        end
        c_seq_done: r_seq_state <= c_seq_idle;
        default:    r_seq_state <= c_seq_idle;
      endcase
    end
  end

  // Per-channel duty and PID state; a fault overrides the sequencer write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_duty_act[c] <= '0;
        r_duty_nxt[c] <= '0;
        r_integ[c]    <= '0;
        r_prev[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_wrap) r_duty_act[c] <= r_duty_nxt[c];
        if (r_seq_state == c_seq_write && r_ch == c_ch_w'(c)) begin
          if (w_run[c]) begin
            r_duty_nxt[c] <= r_res_duty;
            r_integ[c]    <= r_res_integ;
            r_prev[c]     <= r_res_err;
          end else begin
            r_duty_nxt[c] <= '0;
            r_integ[c]    <= '0;
            r_prev[c]     <= '0;
          end
        end
        if (w_trip[c] || w_fault_st[c]) begin
          r_duty_act[c] <= '0;
          r_duty_nxt[c] <= '0;
          r_integ[c]    <= '0;
          r_prev[c]     <= '0;
        end
      end
    end
  end

  servo_pid_core #(
    .POS_W      (POS_W),
    .DUTY_W     (DUTY_W),
    .PWM_PERIOD (PWM_PERIOD),
    .KP         (KP),
    .KI         (KI),
    .KD         (KD),
    .GAIN_SHIFT (GAIN_SHIFT),
    .INT_MAX    (INT_MAX),
    .DUTY_MID   (DUTY_MID)
  ) u_pid (
    .i_sp       (r_op_sp),
    .i_pos      (r_op_pos),
    .i_integ    (r_op_integ),
    .i_prev_err (r_op_prev),
    .o_err      (w_res_err),
    .o_integ    (w_res_integ),
    .o_duty     (w_res_duty)
  );

endmodule
`default_nettype wire
